player_motion_ctrl: RTL

Sequential controller that owns the player sprite's position and animation frame during play stages. It turns held direction keys into one-pixel steps at a fixed move rate. Each step is checked against the stage wall map through a request/acknowledge query port. The block drives the player_x, player_y and player_state inputs of the player sprite renderer in the 320x240 (half-resolution) coordinate space.

---
 rtl/player_motion_ctrl_pkg.sv | 47 ++++
 rtl/player_motion_ctrl_if.sv | 21 ++
 rtl/player_motion_ctrl_move_tick_gen.sv | 27 ++
 rtl/player_motion_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/player_motion_ctrl_pkg.sv
// Shared game definitions: state codes, sprite directions, screen and sprite geometry.
// Also used by the sprite renderer and the top-level game FSM.
package player_motion_ctrl_pkg;

  localparam int unsigned SCREEN_W    = 320;
  localparam int unsigned SCREEN_H    = 240;
  localparam int unsigned SPRITE_SIZE = 10;
  localparam int unsigned COORD_W     = 9;

  typedef enum logic [3:0] {
    GS_TITLE  = 4'd0,
    GS_INTRO1 = 4'd1,
    GS_STAGE1 = 4'd2,
    GS_INTRO2 = 4'd3,
    GS_STAGE2 = 4'd4,
    GS_INTRO3 = 4'd5,
    GS_STAGE3 = 4'd6,
    GS_WIN    = 4'd7,
    GS_FAIL   = 4'd8
  } game_state_e;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_WAIT,
    MS_CHECK,
    MS_STEP
  } motion_state_e;

  function automatic logic is_stage(logic [3:0] s);
    return (s == GS_STAGE1) || (s == GS_STAGE2) || (s == GS_STAGE3);
  endfunction

  // Renderer frame index: three animation phases per facing direction.
  function automatic logic [3:0] frame_index(dir_e d, logic [1:0] phase);
    logic [3:0] f;
    f = ({2'b00, d} * 4'd3) + {2'b00, phase};
    return f;
  endfunction

endpackage

// File: rtl/player_motion_ctrl_if.sv
// Wall-map query handshake between the motion controller (master) and the map lookup (slave).
interface player_motion_ctrl_if;
  import player_motion_ctrl_pkg::*;

  logic               query_valid;
  logic [COORD_W-1:0] query_x;
  logic [COORD_W-1:0] query_y;
  logic               query_ack;
  logic               query_wall;

  modport master (
    output query_valid, query_x, query_y,
    input  query_ack, query_wall
  );

  modport slave (
    input  query_valid, query_x, query_y,
    output query_ack, query_wall
  );

endinterface

// File: rtl/player_motion_ctrl_move_tick_gen.sv
// Free-running divider: counts 0..DIV-1 and flags the last count as a one-cycle tick.
// Generic enough to pace enemy movement as well.
module move_tick_gen #(
  parameter int unsigned DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  always_comb begin
    wrap  = (cnt_q == CW'(DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    tick  = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Player sprite motion: turns held keys into wall-checked one-pixel steps per move tick
// and keeps the sprite position and animation frame for the renderer.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   MS_IDLE  | game state is not a stage
//   MS_WAIT  | in a stage, waiting for a move tick
//   MS_CHECK | wall query outstanding
//   MS_STEP  | commit candidate position, advance animation
module player_motion_ctrl
  import player_motion_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 1_000_000,
  parameter int unsigned ANIM_DIV    = 8,
  parameter int unsigned START_X     = 10,
  parameter int unsigned START_Y     = 10,
  parameter int unsigned X_MAX       = 310,
  parameter int unsigned Y_MAX       = 230,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           state,
  input  logic                 key_up,
  input  logic                 key_down,
  input  logic                 key_left,
  input  logic                 key_right,
  player_motion_ctrl_if.master qif,
  output logic [COORD_W-1:0]   player_x,
  output logic [COORD_W-1:0]   player_y,
  output logic [3:0]           player_state
);

  localparam int unsigned SW = $clog2(ANIM_DIV + 1);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  motion_state_e      ms_q, ms_d;
  logic [3:0]         prev_state_q, prev_state_d;
  logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
  logic [COORD_W-1:0] qx_q, qx_d, qy_q, qy_d;
  logic               qv_q, qv_d;
  dir_e               dir_q, dir_d;
  logic [1:0]         phase_q, phase_d;
  logic [SW-1:0]      step_q, step_d, step_nxt;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [3:0]         ps_q, ps_d;

  logic               tick;
  logic               key_any;
  dir_e               sel_dir;
  logic [COORD_W-1:0] cand_x, cand_y;
  logic               edge_blk;
  logic               stage_chg;
  logic               in_stage;

  move_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Key priority up > down > left > right, and the candidate one pixel that way.
  always_comb begin
    key_any  = key_up | key_down | key_left | key_right;
    sel_dir  = DIR_RIGHT;
    if (key_up)        sel_dir = DIR_UP;
    else if (key_down) sel_dir = DIR_DOWN;
    else if (key_left) sel_dir = DIR_LEFT;
    cand_x   = px_q;
    cand_y   = py_q;
    edge_blk = 1'b0;
    unique case (sel_dir)
      DIR_UP: begin
        edge_blk = (py_q == '0);
        cand_y   = py_q - COORD_W'(1);
      end
      DIR_DOWN: begin
        edge_blk = (py_q >= COORD_W'(Y_MAX));
        cand_y   = py_q + COORD_W'(1);
      end
      DIR_LEFT: begin
        edge_blk = (px_q == '0);
        cand_x   = px_q - COORD_W'(1);
      end
      default: begin
        edge_blk = (px_q >= COORD_W'(X_MAX));
        cand_x   = px_q + COORD_W'(1);
      end
    endcase
  end

  always_comb begin
    ms_d         = ms_q;
    prev_state_d = state;
    px_d         = px_q;
    py_d         = py_q;
    qx_d         = qx_q;
    qy_d         = qy_q;
    qv_d         = qv_q;
    dir_d        = dir_q;
    phase_d      = phase_q;
    step_d       = step_q;
    tmo_d        = tmo_q;
    step_nxt     = step_q + 1'b1;
    stage_chg    = (state != prev_state_q);
    in_stage     = is_stage(state);

    // Any game-state change restarts the player and aborts a pending query,
    // including an ack arriving in the same cycle.
    if (stage_chg) begin
      ms_d    = in_stage ? MS_WAIT : MS_IDLE;
      px_d    = COORD_W'(START_X);
      py_d    = COORD_W'(START_Y);
      dir_d   = DIR_DOWN;
      phase_d = 2'd0;
      step_d  = '0;
      qv_d    = 1'b0;
      tmo_d   = '0;
    end else if (!in_stage) begin
      ms_d  = MS_IDLE;
      qv_d  = 1'b0;
      tmo_d = '0;
    end else begin
      unique case (ms_q)
        MS_IDLE: ms_d = MS_WAIT;
        MS_WAIT: begin
          if (tick) begin
            if (key_any) begin
              dir_d = sel_dir;
              if (!edge_blk) begin
                qx_d  = cand_x;
                qy_d  = cand_y;
                qv_d  = 1'b1;
                tmo_d = TW'(ACK_TIMEOUT);
                ms_d  = MS_CHECK;
              end
            end else begin
              // Standing still restarts the walk cycle from its first frame.
              phase_d = 2'd0;
              step_d  = '0;
            end
          end
        end
        MS_CHECK: begin
          if (qif.query_ack) begin
            qv_d  = 1'b0;
            tmo_d = '0;
            ms_d  = qif.query_wall ? MS_WAIT : MS_STEP;
          end else if (tmo_q <= TW'(1)) begin
            qv_d  = 1'b0;
            tmo_d = '0;
            ms_d  = MS_WAIT;
          end else begin
            tmo_d = tmo_q - 1'b1;
          end
        end
        MS_STEP: begin
          px_d = qx_q;
          py_d = qy_q;
          if (step_nxt == SW'(ANIM_DIV)) begin
            step_d  = '0;
            phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
          end else begin
            step_d = step_nxt;
          end
          ms_d = MS_WAIT;
        end
        default: ms_d = MS_IDLE;
      endcase
    end

    ps_d = frame_index(dir_d, phase_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_q         <= MS_IDLE;
      prev_state_q <= '0;
      px_q         <= COORD_W'(START_X);
      py_q         <= COORD_W'(START_Y);
      qx_q         <= '0;
      qy_q         <= '0;
      qv_q         <= 1'b0;
      dir_q        <= DIR_DOWN;
      phase_q      <= 2'd0;
      step_q       <= '0;
      tmo_q        <= '0;
      ps_q         <= '0;
    end else begin
      ms_q         <= ms_d;
      prev_state_q <= prev_state_d;
      px_q         <= px_d;
      py_q         <= py_d;
      qx_q         <= qx_d;
      qy_q         <= qy_d;
      qv_q         <= qv_d;
      dir_q        <= dir_d;
      phase_q      <= phase_d;
      step_q       <= step_d;
      tmo_q        <= tmo_d;
      ps_q         <= ps_d;
    end
  end

  assign qif.query_valid = qv_q;
  assign qif.query_x     = qx_q;
  assign qif.query_y     = qy_q;
  assign player_x        = px_q;
  assign player_y        = py_q;
  assign player_state    = ps_q;

endmodule
